// File: rtl/wieg_regelaar.sv
// Cradle rocking controller: hill-climbs motor speed/amplitude from the stress-low
// indication counted over fixed evaluation windows, with a quiet cool-down before stopping.
module wieg_regelaar #(
  parameter int WINDOW      = 16,
  parameter int THRESH      = 4,
  parameter int MAX_FAIL    = 3,
  parameter int COOLDOWN    = 2,
  parameter int START_SPEED = 3
) (
  input  logic       clk,
  input  logic       r,
  input  logic       huil_actief,
  input  logic       stress_laag,
  output logic [2:0] snelheid,
  output logic [1:0] amplitude,
  output logic       motor_aan,
  output logic       richting,
  output logic       venster_klaar
);

  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int SW = $clog2(WINDOW + 1);
  localparam int FW = (MAX_FAIL > 1) ? $clog2(MAX_FAIL) : 1;
  localparam int QW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
  localparam logic [SW-1:0] THRESH_C   = SW'(THRESH);
  localparam logic [FW-1:0] FAIL_LAST  = FW'(MAX_FAIL - 1);
  localparam logic [QW-1:0] QUIET_LAST = QW'(COOLDOWN - 1);
  localparam logic [2:0]    START_C    = 3'(START_SPEED);

  typedef enum logic [2:0] {IDLE, START, MEET, EVAL, COOL} state_t;

  state_t        state, stateNext;
  logic [WW-1:0] winCnt, winNext;
  logic [SW-1:0] stressCnt, stressNext;
  logic [FW-1:0] failCnt, failNext;
  logic [QW-1:0] quietCnt, quietNext;
  logic [2:0]    speed, speedNext;
  logic [1:0]    amp, ampNext;
  logic          dir, dirNext;

  // Speed bounces off the ends of 1..7 instead of saturating.
  function automatic logic [2:0] stepSpeed(input logic [2:0] spd, input logic up);
    if (up) stepSpeed = (spd == 3'd7) ? 3'd6 : spd + 3'd1;
    else    stepSpeed = (spd == 3'd1) ? 3'd2 : spd - 3'd1;
  endfunction

  function automatic logic stepDir(input logic [2:0] spd, input logic up);
    if (up && spd == 3'd7)  stepDir = 1'b0;
    else if (!up && spd == 3'd1) stepDir = 1'b1;
    else stepDir = up;
  endfunction

  function automatic logic [1:0] wrapAmp(input logic [1:0] a);
    wrapAmp = (a == 2'd3) ? 2'd1 : a + 2'd1;
  endfunction

  always_comb begin
    stateNext  = state;
    winNext    = winCnt;
    stressNext = stressCnt;
    failNext   = failCnt;
    quietNext  = quietCnt;
    speedNext  = speed;
    ampNext    = amp;
    dirNext    = dir;
    unique case (state)
      IDLE: begin
        if (huil_actief) stateNext = START;
      end
      START: begin
        speedNext  = START_C;
        ampNext    = 2'd1;
        dirNext    = 1'b1;
        winNext    = '0;
        stressNext = '0;
        failNext   = '0;
        quietNext  = '0;
        stateNext  = MEET;
      end
      MEET: begin
        stressNext = stressCnt + SW'(stress_laag);
        if (winCnt == WIN_LAST) begin
          winNext   = '0;
          stateNext = EVAL;
        end else begin
          winNext = winCnt + WW'(1);
        end
      end
      EVAL: begin
        winNext    = '0;
        stressNext = '0;
        if (!huil_actief) begin
          quietNext = '0;
          stateNext = COOL;
        end else begin
          stateNext = MEET;
          if (stressCnt >= THRESH_C) begin
            failNext = '0;
          end else if (failCnt == FAIL_LAST) begin
            // Speed search exhausted at this amplitude: try the next one from scratch.
            failNext  = '0;
            ampNext   = wrapAmp(amp);
            speedNext = START_C;
            dirNext   = 1'b1;
          end else begin
            failNext  = failCnt + FW'(1);
            speedNext = stepSpeed(speed, dir);
            dirNext   = stepDir(speed, dir);
          end
        end
      end
      COOL: begin
        if (huil_actief) begin
          winNext    = '0;
          stressNext = '0;
          stateNext  = MEET;
        end else if (winCnt == WIN_LAST) begin
          winNext = '0;
          if (quietCnt == QUIET_LAST) begin
            quietNext = '0;
            stateNext = IDLE;
          end else begin
            quietNext = quietCnt + QW'(1);
          end
        end else begin
          winNext = winCnt + WW'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state     <= IDLE;
      winCnt    <= '0;
      stressCnt <= '0;
      failCnt   <= '0;
      quietCnt  <= '0;
      speed     <= '0;
      amp       <= '0;
      dir       <= 1'b0;
    end else begin
      state     <= stateNext;
      winCnt    <= winNext;
      stressCnt <= stressNext;
      failCnt   <= failNext;
      quietCnt  <= quietNext;
      speed     <= speedNext;
      amp       <= ampNext;
      dir       <= dirNext;
    end
  end

  // Settings are only visible while the motor runs; IDLE and START show zeros.
  assign motor_aan     = (state == MEET) || (state == EVAL) || (state == COOL);
  assign snelheid      = motor_aan ? speed : 3'd0;
  assign amplitude     = motor_aan ? amp : 2'd0;
  assign richting      = motor_aan ? dir : 1'b0;
  assign venster_klaar = (state == EVAL);

endmodule

// File: tb/tb_wieg_regelaar.sv
// Bench for wieg_regelaar: two instances (MAX_FAIL 3 and 16) driven by random stimulus and
// compared every cycle against a procedural session model of the rocking controller.
module tb_wieg_regelaar;

  localparam int WINDOW      = 16;
  localparam int THRESH      = 4;
  localparam int COOLDOWN    = 2;
  localparam int START_SPEED = 3;

  logic clk = 1'b0;
  logic r = 1'b1;
  logic huil_actief = 1'b0;
  logic stress_laag = 1'b0;

  logic [2:0] snel0, snel1;
  logic [1:0] amp0, amp1;
  logic       on0, on1, dir0, dir1, vk0, vk1;

  int nChecks = 0;
  int nFail   = 0;

  int eSpd[2] = '{0, 0};
  int eAmp[2] = '{0, 0};
  int eDir[2] = '{0, 0};
  int eOn[2]  = '{0, 0};
  int eVk[2]  = '{0, 0};
  bit mValid[2] = '{1'b0, 1'b0};

  wieg_regelaar #(.WINDOW(WINDOW), .THRESH(THRESH), .MAX_FAIL(3), .COOLDOWN(COOLDOWN),
                  .START_SPEED(START_SPEED)) dut0 (
    .clk(clk), .r(r), .huil_actief(huil_actief), .stress_laag(stress_laag),
    .snelheid(snel0), .amplitude(amp0), .motor_aan(on0), .richting(dir0),
    .venster_klaar(vk0)
  );

  wieg_regelaar #(.WINDOW(WINDOW), .THRESH(THRESH), .MAX_FAIL(16), .COOLDOWN(COOLDOWN),
                  .START_SPEED(START_SPEED)) dut1 (
    .clk(clk), .r(r), .huil_actief(huil_actief), .stress_laag(stress_laag),
    .snelheid(snel1), .amplitude(amp1), .motor_aan(on1), .richting(dir1),
    .venster_klaar(vk1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkAll();
    if (mValid[0]) begin
      chk("snelheid0", 32'(snel0), eSpd[0]);
      chk("amplitude0", 32'(amp0), eAmp[0]);
      chk("motor_aan0", 32'(on0), eOn[0]);
      chk("richting0", 32'(dir0), eDir[0]);
      chk("venster_klaar0", 32'(vk0), eVk[0]);
    end
    if (mValid[1]) begin
      chk("snelheid1", 32'(snel1), eSpd[1]);
      chk("amplitude1", 32'(amp1), eAmp[1]);
      chk("motor_aan1", 32'(on1), eOn[1]);
      chk("richting1", 32'(dir1), eDir[1]);
      chk("venster_klaar1", 32'(vk1), eVk[1]);
    end
  endtask

  task automatic mstep(output bit rr, output bit hh, output bit ss);
    @(posedge clk);
    rr = r;
    hh = huil_actief;
    ss = stress_laag;
  endtask

  // One rocking session written as a straight-line program: wait for crying, start,
  // then repeat measure/evaluate windows. Returns on reset or when the cool-down expires.
  task automatic runSession(input int id, input int mf);
    bit rr, hh, ss, resumed;
    int spd, amp, dir, fails, cnt;
    eOn[id] = 0; eSpd[id] = 0; eAmp[id] = 0; eDir[id] = 0; eVk[id] = 0;
    forever begin
      mstep(rr, hh, ss);
      if (rr) return;
      if (hh) break;
    end
    mstep(rr, hh, ss);
    if (rr) return;
    spd = START_SPEED; amp = 1; dir = 1; fails = 0;
    forever begin
      eOn[id] = 1; eSpd[id] = spd; eAmp[id] = amp; eDir[id] = dir; eVk[id] = 0;
      cnt = 0;
      for (int i = 0; i < WINDOW; i++) begin
        mstep(rr, hh, ss);
        if (rr) return;
        cnt += int'(ss);
      end
      eVk[id] = 1;
      mstep(rr, hh, ss);
      if (rr) return;
      eVk[id] = 0;
      if (!hh) begin
        resumed = 0;
        for (int q = 0; q < COOLDOWN * WINDOW; q++) begin
          mstep(rr, hh, ss);
          if (rr) return;
          if (hh) begin
            resumed = 1;
            break;
          end
        end
        if (!resumed) return;
      end else if (cnt >= THRESH) begin
        fails = 0;
      end else if (fails + 1 == mf) begin
        fails = 0;
        amp = amp % 3 + 1;
        spd = START_SPEED;
        dir = 1;
      end else begin
        fails++;
        if (dir == 1 && spd == 7) begin
          dir = 0; spd = 6;
        end else if (dir == 0 && spd == 1) begin
          dir = 1; spd = 2;
        end else begin
          spd += (dir == 1) ? 1 : -1;
        end
      end
    end
  endtask

  initial begin
    bit rr, hh, ss;
    forever begin
      mstep(rr, hh, ss);
      if (rr) break;
    end
    mValid[0] = 1'b1;
    forever runSession(0, 3);
  end

  initial begin
    bit rr, hh, ss;
    forever begin
      mstep(rr, hh, ss);
      if (rr) break;
    end
    mValid[1] = 1'b1;
    forever runSession(1, 16);
  end

  task automatic cyc(input bit rr, input bit hh, input bit ss);
    @(negedge clk);
    checkAll();
    r = rr;
    huil_actief = hh;
    stress_laag = ss;
  endtask

  initial begin
    int len, sProb, mode, hLeft;
    bit h, rr;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    h = 1'b1;
    for (int seg = 0; seg < 26; seg++) begin
      if (seg == 0) begin
        mode = 0; sProb = 0; len = 420;
      end else if (seg == 1) begin
        mode = 0; sProb = 4; len = 300;
      end else begin
        mode = int'($urandom_range(0, 3));
        len  = int'($urandom_range(120, 400));
        case ($urandom_range(0, 3))
          0:       sProb = 0;
          1:       sProb = 3;
          2:       sProb = 4;
          default: sProb = 9;
        endcase
      end
      hLeft = 0;
      for (int c = 0; c < len; c++) begin
        rr = 1'b0;
        if (mode == 0 || mode == 2) begin
          h = 1'b1;
        end else begin
          if (hLeft == 0) begin
            h = !h;
            if (h) hLeft = int'($urandom_range(20, 200));
            else if (mode == 3) hLeft = int'($urandom_range(30, 80));
            else hLeft = int'($urandom_range(1, 12));
          end
          hLeft--;
        end
        if (mode == 2 && $urandom_range(0, 199) == 0) rr = 1'b1;
        cyc(rr, h, $urandom_range(0, 15) < sProb);
      end
    end
    for (int c = 0; c < 40; c++) cyc(1'b0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end

endmodule
